fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction fetch and issue sequencer that drives the ALU's instruction-side inputs and consumes its next-PC result. It owns the 9-bit program counter and fetches 9-bit instructions from a synchronous instruction ROM. It splits each instruction into the OPCODE/FLAG_REG2/REG1 fields, presents them to the ALU for one execute cycle, and then commits the ALU's PCOUT as the next PC. It sits between the instruction ROM and the ALU and stops on the halt opcode.

## Interface
Parameters:
- HALT_OP, default 5'b11111: opcode that stops execution. It is kHLT, taken from the shared package.
- CNT_W, default 16: width of the retired-instruction counter.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- START  in  1  one-cycle pulse; loads PC from START_PC and begins fetching.
- START_PC  in  9  first instruction address.
- IMEM_ADDR  out  9  ROM read address.
- IMEM_DATA  in  9  ROM read data, valid the cycle after IMEM_ADDR.
- PC  out  9  current program counter, fed to the ALU PC input.
- OPCODE  out  5  equals IR[8:4].
- FLAG_REG2  out  2  equals IR[3:2].
- REG1  out  2  equals IR[1:0].
- INST_VALID  out  1  high only in EXEC; the fields are meaningful and the ALU result commits this cycle.
- PCOUT  in  9  next PC from the ALU; sampled at the end of EXEC.
- DONE  out  1  high while in HALT.
- INST_COUNT  out  CNT_W  number of retired instructions.

## Operation
- State machine states: IDLE, FETCH, WAIT, EXEC, HALT. The state register is reset to IDLE.
- IDLE: all outputs hold. START=1 sets PC<=START_PC, clears INST_COUNT and moves to FETCH.
- FETCH: IMEM_ADDR=PC. Moves to WAIT unconditionally.
- WAIT: IMEM_DATA is valid in this cycle.
  - If IMEM_DATA[8:4]==HALT_OP, move to HALT. IR is not loaded, PC is unchanged, INST_COUNT is unchanged.
  - Otherwise IR<=IMEM_DATA and move to EXEC.
- EXEC: INST_VALID=1 and the fields come from IR. At the clock edge: PC<=PCOUT, INST_COUNT<=INST_COUNT+1, move to FETCH.
- HALT: DONE=1. START=1 behaves exactly as in IDLE (restart from START_PC, DONE falls on the next cycle).
- START is ignored in FETCH, WAIT and EXEC.
- Arithmetic and width rules:
  - PC is taken verbatim from the 9-bit PCOUT. Wrap-around (511→0) is the ALU's responsibility.
  - The sequencer never adds to PC itself.
  - INST_COUNT saturates at all-ones and does not wrap.
- Reset (asynchronous, at any point including mid-instruction):
  - state=IDLE.
  - PC, IR, IMEM_ADDR, INST_COUNT = 0.
  - INST_VALID=0, DONE=0.
  - OPCODE, FLAG_REG2, REG1 = 0.
  - After RST_N deasserts, nothing happens until START.
- IMEM_ADDR is registered. It holds the last fetched address outside FETCH and is 0 after reset.
- OPCODE, FLAG_REG2 and REG1 follow IR at all times. Consumers must qualify them with INST_VALID.

## Timing
- Throughput is 3 cycles per retired instruction: FETCH, WAIT, EXEC.
- Latency from START:
  - The START edge loads PC; the next cycle is FETCH.
  - The first INST_VALID is 3 cycles after the START edge.
- PCOUT must be combinationally valid during EXEC. It is sampled only on the EXEC→FETCH edge.
- Halt latency: DONE rises on the edge that ends WAIT of the halt instruction. The halt instruction never produces INST_VALID.
- START held high for several cycles in IDLE/HALT acts as a single start. The FSM leaves IDLE/HALT on the first cycle and ignores START afterwards.

## Structure
- The shared `definitions` package holds the opcode enum (kADD…kJUM), the flag constants (kZER, kONS, kONE, kSEV) and the new kHLT=5'b11111.
- Put the instruction field offsets in the package as localparams.
- Put the state enum (IDLE, FETCH, WAIT, EXEC, HALT) in the package so the bench can probe the state.
- No sub-module is needed. One FSM with a datapath for PC, IR and the counter.
- The fetch_sequencer + ALU pairing is wired at the top level.

## Test plan
- Reset mid-EXEC: drop RST_N with PC=0x23 → all outputs 0 and state IDLE with no clock edge; no activity until START.
- START_PC=0x010, ROM[0x010]=9'b00001_00_01, ALU model returns PCOUT=0x011 → INST_VALID exactly on the 3rd cycle after START with OPCODE=5'b00001, REG1=2'b01; then PC=0x011 and INST_COUNT=1.
- Branch: EXEC with PCOUT=0x1F0 → next IMEM_ADDR=0x1F0. Wrap: PC=0x1FF, PCOUT=0x000 → next IMEM_ADDR=0x000.
- Halt: ROM[0x012]=9'h1F0 after two normal instructions → DONE=1 and INST_COUNT=2; no INST_VALID for the halt word; PC stays 0x012.
- START pulsed during EXEC → ignored (PC follows PCOUT). START in HALT with START_PC=0x005 → DONE falls next cycle, fetch resumes at 0x005, INST_COUNT=0.
- Saturation: CNT_W=4, run 20 non-halt instructions → INST_COUNT reaches 4'hF and holds.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared ALU/sequencer definitions: opcodes, flag encodings, instruction field
// offsets and the sequencer state encoding.
package definitions;

  typedef enum logic [4:0] {
    kADD = 5'd0,  kADI = 5'd1,  kSUB = 5'd2,  kSBI = 5'd3,
    kAND = 5'd4,  kOR  = 5'd5,  kXOR = 5'd6,  kNOT = 5'd7,
    kSHL = 5'd8,  kSHR = 5'd9,  kLD  = 5'd10, kST  = 5'd11,
    kBEQ = 5'd12, kBNE = 5'd13, kJUM = 5'd14
  } opcode_e;

  localparam logic [1:0] kZER = 2'b00;
  localparam logic [1:0] kONE = 2'b01;
  localparam logic [1:0] kSEV = 2'b10;
  localparam logic [1:0] kONS = 2'b11;

  localparam logic [4:0] kHLT = 5'b11111;

  // IR layout: [8:4] opcode, [3:2] flag/reg2, [1:0] reg1
  localparam int unsigned OP_MSB  = 8;
  localparam int unsigned OP_LSB  = 4;
  localparam int unsigned FR2_MSB = 3;
  localparam int unsigned FR2_LSB = 2;
  localparam int unsigned R1_MSB  = 1;
  localparam int unsigned R1_LSB  = 0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    EXEC  = 3'd3,
    HALT  = 3'd4
  } seq_state_e;

endpackage

// File: rtl/fetch_sequencer.sv
// Fetch/issue sequencer: FETCH -> WAIT -> EXEC per instruction, PC committed
// from the ALU's PCOUT, stops on the halt opcode.
module fetch_sequencer
  import definitions::*;
#(
  parameter logic [4:0]  HALT_OP = kHLT,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [8:0]       START_PC,
  output logic [8:0]       IMEM_ADDR,
  input  logic [8:0]       IMEM_DATA,
  output logic [8:0]       PC,
  output logic [4:0]       OPCODE,
  output logic [1:0]       FLAG_REG2,
  output logic [1:0]       REG1,
  output logic             INST_VALID,
  input  logic [8:0]       PCOUT,
  output logic             DONE,
  output logic [CNT_W-1:0] INST_COUNT
);

  seq_state_e       state_q;
  logic [8:0]       pc_q, ir_q, imem_addr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, done_q;

  // Retired count sticks at all-ones instead of wrapping
  assign cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      ir_q        <= '0;
      imem_addr_q <= '0;
      cnt_q       <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE, HALT: begin
          if (START) begin
            pc_q        <= START_PC;
            imem_addr_q <= START_PC;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            state_q     <= FETCH;
          end
        end
        FETCH: state_q <= WAIT;
        WAIT: begin
          if (IMEM_DATA[OP_MSB:OP_LSB] == HALT_OP) begin
            done_q  <= 1'b1;
            state_q <= HALT;
          end else begin
            ir_q    <= IMEM_DATA;
            valid_q <= 1'b1;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          // Address register is loaded together with PC so FETCH presents it
          pc_q        <= PCOUT;
          imem_addr_q <= PCOUT;
          cnt_q       <= cnt_d;
          valid_q     <= 1'b0;
          state_q     <= FETCH;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign IMEM_ADDR  = imem_addr_q;
  assign PC         = pc_q;
  assign OPCODE     = ir_q[OP_MSB:OP_LSB];
  assign FLAG_REG2  = ir_q[FR2_MSB:FR2_LSB];
  assign REG1       = ir_q[R1_MSB:R1_LSB];
  assign INST_VALID = valid_q;
  assign DONE       = done_q;
  assign INST_COUNT = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: ROM and ALU next-PC models, two DUTs
// (default counter width and a 4-bit counter for saturation).
module tb_fetch_sequencer;
  import definitions::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [8:0] rom [512];

  // DUT a: default parameters
  logic        start_a;
  logic [8:0]  start_pc_a, addr_a, rdata_a, pc_a, pcout_a, alu_pc;
  logic [4:0]  op_a;
  logic [1:0]  fr2_a, r1_a;
  logic        valid_a, done_a, alu_ovr;
  logic [15:0] cnt_a;

  // DUT b: 4-bit counter
  logic        start_b;
  logic [8:0]  start_pc_b, addr_b, rdata_b, pc_b, pcout_b;
  logic [4:0]  op_b;
  logic [1:0]  fr2_b, r1_b;
  logic        valid_b, done_b;
  logic [3:0]  cnt_b;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rdata_a <= rom[addr_a];
  always @(posedge clk) rdata_b <= rom[addr_b];

  assign pcout_a = alu_ovr ? alu_pc : pc_a + 9'd1;
  assign pcout_b = pc_b + 9'd1;

  fetch_sequencer dut_a (
    .CLK(clk), .RST_N(rst_n), .START(start_a), .START_PC(start_pc_a),
    .IMEM_ADDR(addr_a), .IMEM_DATA(rdata_a), .PC(pc_a), .OPCODE(op_a),
    .FLAG_REG2(fr2_a), .REG1(r1_a), .INST_VALID(valid_a), .PCOUT(pcout_a),
    .DONE(done_a), .INST_COUNT(cnt_a)
  );

  fetch_sequencer #(.CNT_W(4)) dut_b (
    .CLK(clk), .RST_N(rst_n), .START(start_b), .START_PC(start_pc_b),
    .IMEM_ADDR(addr_b), .IMEM_DATA(rdata_b), .PC(pc_b), .OPCODE(op_b),
    .FLAG_REG2(fr2_b), .REG1(r1_b), .INST_VALID(valid_b), .PCOUT(pcout_b),
    .DONE(done_b), .INST_COUNT(cnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    rst_n = 1'b1; start_a = 1'b0; start_pc_a = '0; alu_ovr = 1'b0; alu_pc = '0;
    start_b = 1'b0; start_pc_b = '0;
    for (int i = 0; i < 512; i++) rom[i] = 9'h000;
    rom[9'h010] = 9'b00001_00_01;
    rom[9'h011] = 9'b00010_10_11;
    rom[9'h012] = 9'h1F0;
    rom[9'h005] = 9'b00011_01_00;
    rom[9'h1F0] = 9'b00100_11_10;
    rom[9'h1FF] = 9'b00101_00_11;
    rom[9'h000] = 9'b01110_01_01;
    rom[9'h023] = 9'b00110_10_10;

    #2 rst_n = 1'b0;
    #1;
    chk("rst_state", dut_a.state_q, IDLE);
    chk("rst_pc",    pc_a,    0);
    chk("rst_addr",  addr_a,  0);
    chk("rst_valid", valid_a, 0);
    chk("rst_done",  done_a,  0);
    chk("rst_cnt",   cnt_a,   0);
    chk("rst_op",    op_a,    0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    ticks(3);
    chk("idle_hold_state", dut_a.state_q, IDLE);
    chk("idle_hold_addr",  addr_a, 0);

    // First instruction at 0x010
    @(negedge clk); start_pc_a = 9'h010; start_a = 1'b1;
    tick(); start_a = 1'b0;
    chk("s1_state_fetch", dut_a.state_q, FETCH);
    chk("s1_pc",    pc_a,   9'h010);
    chk("s1_addr",  addr_a, 9'h010);
    chk("s1_valid", valid_a, 0);
    tick();
    chk("s2_state_wait", dut_a.state_q, WAIT);
    chk("s2_valid", valid_a, 0);
    tick();
    chk("s3_valid", valid_a, 1);
    chk("s3_op",    op_a,  5'b00001);
    chk("s3_fr2",   fr2_a, 2'b00);
    chk("s3_reg1",  r1_a,  2'b01);
    tick();
    chk("i1_pc",    pc_a,   9'h011);
    chk("i1_cnt",   cnt_a,  1);
    chk("i1_addr",  addr_a, 9'h011);
    chk("i1_valid", valid_a, 0);

    // Second instruction; START during EXEC must be ignored
    ticks(2);
    chk("i2_valid", valid_a, 1);
    chk("i2_op",    op_a,  5'b00010);
    chk("i2_fr2",   fr2_a, 2'b10);
    chk("i2_reg1",  r1_a,  2'b11);
    start_pc_a = 9'h0AA; start_a = 1'b1;
    tick(); start_a = 1'b0;
    chk("ign_pc",    pc_a, 9'h012);
    chk("ign_cnt",   cnt_a, 2);
    chk("ign_state", dut_a.state_q, FETCH);

    // Halt word at 0x012
    tick();
    chk("h_wait_valid", valid_a, 0);
    chk("h_wait_done",  done_a, 0);
    tick();
    chk("h_done",  done_a, 1);
    chk("h_state", dut_a.state_q, HALT);
    chk("h_valid", valid_a, 0);
    chk("h_cnt",   cnt_a, 2);
    chk("h_pc",    pc_a, 9'h012);
    tick();
    chk("h_hold_done",  done_a, 1);
    chk("h_hold_valid", valid_a, 0);

    // Restart from HALT at 0x005, then branch and wrap via PCOUT
    @(negedge clk); start_pc_a = 9'h005; start_a = 1'b1;
    tick(); start_a = 1'b0;
    chk("r_done",  done_a, 0);
    chk("r_cnt",   cnt_a, 0);
    chk("r_pc",    pc_a, 9'h005);
    chk("r_addr",  addr_a, 9'h005);
    ticks(2);
    chk("r_valid", valid_a, 1);
    chk("r_op",    op_a, 5'b00011);
    alu_ovr = 1'b1; alu_pc = 9'h1F0;
    tick();
    chk("br_addr", addr_a, 9'h1F0);
    chk("br_pc",   pc_a, 9'h1F0);
    chk("br_cnt",  cnt_a, 1);
    ticks(2);
    chk("br_op", op_a, 5'b00100);
    alu_pc = 9'h1FF;
    tick();
    ticks(2);
    chk("wr_pre_pc", pc_a, 9'h1FF);
    alu_pc = 9'h000;
    tick();
    chk("wr_addr", addr_a, 9'h000);
    chk("wr_pc",   pc_a, 9'h000);
    ticks(2);
    chk("wr_op", op_a, 5'b01110);
    alu_pc = 9'h023;
    tick();
    ticks(2);
    chk("mid_exec_valid", valid_a, 1);
    chk("mid_exec_pc",    pc_a, 9'h023);

    // Asynchronous reset in the middle of EXEC
    rst_n = 1'b0;
    #1;
    chk("ar_state", dut_a.state_q, IDLE);
    chk("ar_pc",    pc_a, 0);
    chk("ar_addr",  addr_a, 0);
    chk("ar_valid", valid_a, 0);
    chk("ar_cnt",   cnt_a, 0);
    chk("ar_op",    op_a, 0);
    chk("ar_fr2",   fr2_a, 0);
    chk("ar_reg1",  r1_a, 0);
    alu_ovr = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    ticks(4);
    chk("ar_quiet_state", dut_a.state_q, IDLE);
    chk("ar_quiet_addr",  addr_a, 0);

    // START held three cycles acts as one start
    @(negedge clk); start_pc_a = 9'h010; start_a = 1'b1;
    tick();
    tick();
    chk("hold_state_wait", dut_a.state_q, WAIT);
    chk("hold_pc", pc_a, 9'h010);
    tick(); start_a = 1'b0;
    chk("hold_valid", valid_a, 1);
    tick();
    chk("hold_cnt", cnt_a, 1);

    // Counter saturation on the 4-bit instance
    @(negedge clk); start_pc_b = 9'h100; start_b = 1'b1;
    tick(); start_b = 1'b0;
    ticks(30);
    chk("sat_cnt10", cnt_b, 4'd10);
    ticks(15);
    chk("sat_cnt15", cnt_b, 4'hF);
    ticks(15);
    chk("sat_hold", cnt_b, 4'hF);
    chk("sat_pc",   pc_b, 9'h114);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
